pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC value loaded on reset (bits [1:0] shall be 0).
REQ-002 SHALL have parameter INCR, default 32'd4, meaning the sequential PC increment.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port stall  input  1  1 = hold the PC and issue no new fetch request.
REQ-006 SHALL have port br_taken  input  1  one-cycle redirect request from the branch unit.
REQ-007 SHALL have port br_target  input  32  redirect address, sampled when br_taken=1.
REQ-008 SHALL have port imem_ack  input  1  instruction memory accepts the current request.
REQ-009 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-010 SHALL have port imem_addr  output  32  fetch address; equals pc.
REQ-011 SHALL have port pc  output  32  current program counter.
REQ-012 SHALL have port pc_plus4  output  32  pc + INCR, combinational; feeds the 32-bit 2:1 next-PC select, input a.
REQ-013 SHALL have port fetch_valid  output  1  registered; 1 for one cycle after each non-squashed completed fetch.

Function
REQ-014 SHALL implement states BOOT, FETCH and HOLD.
REQ-015 BOOT: imem_req=0; SHALL go to FETCH on the next edge unconditionally.
REQ-016 FETCH: imem_req=1 when stall=0; if stall=1, imem_req=0 and SHALL go to HOLD.
REQ-017 HOLD: imem_req=0; SHALL return to FETCH on the first edge where stall=0.
REQ-018 Handshake completes on an edge where imem_req=1 and imem_ack=1; imem_ack while imem_req=0 SHALL be ignored.
REQ-019 On a completed handshake, pc SHALL load next_pc = redirect ? target_sel : pc_plus4 (2:1 select, s=redirect).
REQ-020 redirect = br_taken OR pending; target_sel = br_taken ? br_target : pend_target (the current cycle's br_taken wins).
REQ-021 br_taken without a completed handshake SHALL set pending=1 and store br_target in pend_target; a later br_taken SHALL overwrite pend_target.
REQ-022 pending SHALL clear on the handshake that consumes it.
REQ-023 fetch_valid SHALL be 1 in the cycle after a completed handshake only if redirect was 0 at that handshake; a redirecting handshake SHALL be squashed (fetch_valid=0).
REQ-024 Without a handshake, pc SHALL hold (including during stall and HOLD).
REQ-025 Address arithmetic SHALL be modulo 2^32: pc=32'hFFFFFFFC, INCR=4 gives 32'h00000000.
REQ-026 br_target[1:0] SHALL be forced to 2'b00 when loaded into pc or pend_target.
REQ-027 stall=1 SHALL NOT block recording of br_taken into pend_target.
REQ-028 Latency: the first imem_req SHALL assert 1 cycle after reset release (BOOT lasts 1 cycle).

Reset
REQ-029 rst_n=0 SHALL immediately, independent of clk, set: pc=RESET_PC, state=BOOT, pending=0, pend_target=0, imem_req=0, fetch_valid=0.
REQ-030 An asynchronous reset during an outstanding request SHALL drop imem_req in the same cycle; the in-flight fetch SHALL be discarded.
REQ-031 After reset release, operation SHALL restart from BOOT.

Verification
REQ-032 Reset release, stall=0, imem_ack=1 every cycle -> imem_req rises after 1 cycle; pc = 0,4,8,C on successive edges; fetch_valid=1 each cycle after the first handshake.
REQ-033 pc=32'h00000010, br_taken=1, br_target=32'h00000103, ack=1 in the same cycle -> pc=32'h00000100 next edge; fetch_valid=0 for that fetch.
REQ-034 imem_ack=0 with br_taken=1 (target 32'h00000200), then ack=1 two cycles later -> pending=1 until the ack; pc=32'h00000200 after the ack; that fetch squashed.
REQ-035 stall=1 for 3 cycles at pc=32'h00000020 -> imem_req=0, pc holds 32'h00000020; after stall drops, one HOLD->FETCH edge, then pc=32'h00000024 on the next ack.
REQ-036 pc=32'hFFFFFFFC, ack=1 -> pc=32'h00000000; rst_n pulsed low mid-fetch -> imem_req=0 immediately, pc=RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction-fetch sequencer.
//   clk, rst_n          : clock, asynchronous active-low reset
//   stall               : hold the PC and issue no fetch request
//   br_taken, br_target : one-cycle redirect request and its address
//   imem_ack            : instruction memory accepts the current request
//   imem_req, imem_addr : fetch request and address (address equals pc)
//   pc, pc_plus4        : current PC and its sequential successor
//   fetch_valid         : pulses the cycle after a non-squashed fetch completes
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] INCR     = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              pending_q, pending_d;
  logic [XLEN-1:0]   pend_target_q, pend_target_d;
  logic              fetch_valid_q, fetch_valid_d;

  logic              handshake;
  logic              redirect;
  logic [XLEN-1:0]   br_target_al;
  logic [XLEN-1:0]   target_sel;
  logic [XLEN-1:0]   next_pc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: if (stall) state_d = ST_HOLD;
      ST_HOLD:  if (!stall) state_d = ST_FETCH;
      default:  state_d = ST_BOOT;
    endcase
  end

  // Output logic: request follows state directly so reset drops it at once
  always_comb begin
    imem_req = 1'b0;
    case (state_q)
      ST_FETCH: imem_req = ~stall;
      default:  imem_req = 1'b0;
    endcase
  end

  // Redirect selection; a branch in the current cycle beats a pending one
  assign handshake    = imem_req & imem_ack;
  assign redirect     = br_taken | pending_q;
  assign br_target_al = {br_target[XLEN-1:2], 2'b00};
  assign target_sel   = br_taken ? br_target_al : pend_target_q;
  assign pc_plus4     = XLEN'(pc_q + INCR);
  assign next_pc      = redirect ? target_sel : pc_plus4;

  // Datapath next-state
  always_comb begin
    pc_d          = pc_q;
    pending_d     = pending_q;
    pend_target_d = pend_target_q;
    fetch_valid_d = handshake & ~redirect;
    if (handshake) begin
      pc_d      = next_pc;
      pending_d = 1'b0;
    end else if (br_taken) begin
      // Remember the redirect until a fetch can consume it, even while stalled
      pending_d     = 1'b1;
      pend_target_d = br_target_al;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      pending_q     <= 1'b0;
      pend_target_q <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      pending_q     <= pending_d;
      pend_target_q <= pend_target_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign fetch_valid = fetch_valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INCR     = 32'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        imem_ack = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;

  pc_fetch_unit #(.RESET_PC(RESET_PC), .INCR(INCR)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .imem_ack(imem_ack), .imem_req(imem_req),
    .imem_addr(imem_addr), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] pc;
    logic [31:0] nxt;
    logic        fv;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: what the fetch unit has promised so far
  logic [31:0] m_pc;
  logic [31:0] m_ptgt;
  bit          m_pend;
  bit          m_fv;
  bit          m_boot;   // first cycle after reset: never fetches
  bit          m_hold;   // a stalled cycle costs one dead cycle after stall drops

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_pc   = RESET_PC;
    m_ptgt = '0;
    m_pend = 1'b0;
    m_fv   = 1'b0;
    m_boot = 1'b1;
    m_hold = 1'b0;
  endtask

  // Drive one cycle's inputs (caller is at a negedge) and predict its outputs
  task automatic apply(input bit s, input bit b, input logic [31:0] t, input bit a);
    exp_t        e;
    bit          req, hs, redir;
    logic [31:0] tgt;
    stall = s; br_taken = b; br_target = t; imem_ack = a;
    req = !m_boot && !m_hold && !s;
    e.req = req; e.pc = m_pc; e.nxt = m_pc + INCR; e.fv = m_fv;
    sb.push_back(e);
    hs    = req && a;
    redir = b || m_pend;
    tgt   = b ? (t & 32'hFFFF_FFFC) : m_ptgt;
    m_fv  = hs && !redir;
    if (hs) begin
      m_pc   = redir ? tgt : m_pc + INCR;
      m_pend = 1'b0;
    end else if (b) begin
      m_pend = 1'b1;
      m_ptgt = t & 32'hFFFF_FFFC;
    end
    m_hold = !m_boot && s;
    m_boot = 1'b0;
  endtask

  task automatic step(input bit s, input bit b, input logic [31:0] t, input bit a);
    @(negedge clk);
    apply(s, b, t, a);
  endtask

  // Asynchronous reset mid-cycle, then release at a negedge
  task automatic mid_reset();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_fv", 32'(fetch_valid), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  // Monitor: every cycle the bench has a prediction for, compare outputs
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("imem_req", 32'(imem_req), 32'(e.req));
        chk("pc", pc, e.pc);
        chk("imem_addr", imem_addr, e.pc);
        chk("pc_plus4", pc_plus4, e.nxt);
        chk("fetch_valid", 32'(fetch_valid), 32'(e.fv));
      end
    end
  end

  initial begin
    logic [31:0] t;
    model_reset();
    #1;
    chk("por_pc", pc, RESET_PC);
    chk("por_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, 1'b0, 32'h0, 1'b1);            // BOOT cycle
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);  // pc 0,4,8,C
    #3 chk("seq_pc", pc, 32'h0000_000C);
    chk("seq_fv", 32'(fetch_valid), 32'd1);

    step(1'b0, 1'b1, 32'h0000_0103, 1'b1);     // branch at pc=0x10
    step(1'b0, 1'b0, 32'h0, 1'b0);
    #3 chk("br_pc", pc, 32'h0000_0100);
    chk("br_fv", 32'(fetch_valid), 32'd0);

    step(1'b0, 1'b1, 32'h0000_0200, 1'b0);     // branch without ack
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);             // ack consumes pending
    step(1'b0, 1'b0, 32'h0, 1'b0);
    #3 chk("pend_pc", pc, 32'h0000_0200);
    chk("pend_fv", 32'(fetch_valid), 32'd0);

    step(1'b0, 1'b1, 32'h0000_0020, 1'b1);
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
    #3 chk("stall_pc", pc, 32'h0000_0020);
    chk("stall_req", 32'(imem_req), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);             // restart cycle
    #3 chk("restart_req", 32'(imem_req), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    #3 chk("resume_pc", pc, 32'h0000_0024);
    chk("resume_fv", 32'(fetch_valid), 32'd1);

    step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);     // target low bits dropped
    step(1'b0, 1'b0, 32'h0, 1'b1);
    #3 chk("wrap_at", pc, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    #3 chk("wrap_pc", pc, 32'h0000_0000);

    step(1'b0, 1'b0, 32'h0, 1'b0);             // request outstanding
    mid_reset();

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: t = $urandom;
      endcase
      step($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, t,
           $urandom_range(0, 2) != 0);
      if ($urandom_range(0, 60) == 0) mid_reset();
    end

    @(negedge clk);
    #4 chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
